// File: rtl/vi_adc_capture_if.sv
// Serial ADC bus shared by the V/I capture front end and the ADC.
// cnv/sclk driven by master (capture), sdo_v/sdo_i driven by slave (ADC).
interface vi_adc_capture_if;
  logic adc_cnv;
  logic adc_sclk;
  logic adc_sdo_v;
  logic adc_sdo_i;

  modport master (
    output adc_cnv,
    output adc_sclk,
    input  adc_sdo_v,
    input  adc_sdo_i
  );

  modport slave (
    input  adc_cnv,
    input  adc_sclk,
    output adc_sdo_v,
    output adc_sdo_i
  );
endinterface

// File: rtl/vi_adc_capture.sv
// Dual-channel serial ADC sequencer: V/I codes -> Q1.15, box-car averaged.
// Ports: clk, rst_n, enable, adc (bus master), v_out/i_out, sample_valid, clip_v/i, overrun.
module vi_adc_capture #(
  parameter int ADC_BITS      = 12,
  parameter int CLK_DIV       = 4,
  parameter int CONV_CYCLES   = 40,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int AVG_LOG2      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  vi_adc_capture_if.master    adc,
  output logic [15:0]         v_out,
  output logic [15:0]         i_out,
  output logic                sample_valid,
  output logic                clip_v,
  output logic                clip_i,
  output logic                overrun
);

  localparam int PER    = 2 * CLK_DIV;
  localparam int CMAX   = (CONV_CYCLES > PER) ? CONV_CYCLES : PER;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int BW     = $clog2(ADC_BITS + 1);
  localparam int TW     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int AW     = 16 + AVG_LOG2;
  localparam int FW     = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FRAMES = 1 << AVG_LOG2;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [TW-1:0] tcnt;
  logic          tick;

  logic [CW-1:0] cyc;
  logic [BW-1:0] bits;
  logic          last_conv;
  logic          last_half;
  logic          last_bit;
  logic          rise;

  logic [ADC_BITS-1:0] sh_v;
  logic [ADC_BITS-1:0] sh_i;
  logic [15:0]         q_v;
  logic [15:0]         q_i;
  logic                hit_v;
  logic                hit_i;

  logic signed [AW-1:0] acc_v;
  logic signed [AW-1:0] acc_i;
  logic signed [AW-1:0] sum_v;
  logic signed [AW-1:0] sum_i;
  logic [FW-1:0]        fcnt;
  logic                 last_frame;
  logic                 win_clip_v;
  logic                 win_clip_i;

  // Frame tick: held at 0 while disabled so sampling restarts cleanly.
  assign tick = enable && (tcnt == TW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (!enable || tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign last_conv = (cyc == CW'(CONV_CYCLES - 1));
  assign last_half = (cyc == CW'(PER - 1));
  assign last_bit  = (bits == BW'(ADC_BITS - 1));
  // SDO is captured on the edge that raises SCLK; the ADC moves it on the fall.
  assign rise      = (state == SHIFT) && (cyc == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (tick) state_n = CONV;
      CONV:    if (last_conv) state_n = SHIFT;
      SHIFT:   if (last_half && last_bit) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (!enable) state_n = IDLE;
  end

  always_comb begin
    adc.adc_cnv  = (state == CONV);
    adc.adc_sclk = (state == SHIFT) && (cyc >= CW'(CLK_DIV));
    overrun      = tick && (state != IDLE);
  end

  // cyc times CONV and each SCLK period; bits counts completed periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc  <= '0;
      bits <= '0;
    end else if (state_n != state) begin
      cyc  <= '0;
      bits <= '0;
    end else if (state == CONV) begin
      cyc <= cyc + CW'(1);
    end else if (state == SHIFT) begin
      if (last_half) begin
        cyc  <= '0;
        bits <= bits + BW'(1);
      end else begin
        cyc <= cyc + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_v <= '0;
      sh_i <= '0;
    end else if (rise) begin
      sh_v <= {sh_v[ADC_BITS-2:0], adc.adc_sdo_v};
      sh_i <= {sh_i[ADC_BITS-2:0], adc.adc_sdo_i};
    end
  end

  // Offset binary to two's complement is an MSB flip, then left-justify.
  assign q_v = 16'({~sh_v[ADC_BITS-1], sh_v[ADC_BITS-2:0]})
               << (16 - ADC_BITS);
  assign q_i = 16'({~sh_i[ADC_BITS-1], sh_i[ADC_BITS-2:0]})
               << (16 - ADC_BITS);

  assign hit_v = (sh_v == '0) || (sh_v == '1);
  assign hit_i = (sh_i == '0) || (sh_i == '1);

  assign sum_v = acc_v + AW'(signed'(q_v));
  assign sum_i = acc_i + AW'(signed'(q_i));

  assign last_frame = (fcnt == FW'(FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_v        <= '0;
      acc_i        <= '0;
      fcnt         <= '0;
      win_clip_v   <= 1'b0;
      win_clip_i   <= 1'b0;
      v_out        <= '0;
      i_out        <= '0;
      clip_v       <= 1'b0;
      clip_i       <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (!enable) begin
        acc_v      <= '0;
        acc_i      <= '0;
        fcnt       <= '0;
        win_clip_v <= 1'b0;
        win_clip_i <= 1'b0;
      end else if (state == DONE) begin
        if (last_frame) begin
          v_out        <= 16'(sum_v >>> AVG_LOG2);
          i_out        <= 16'(sum_i >>> AVG_LOG2);
          clip_v       <= win_clip_v | hit_v;
          clip_i       <= win_clip_i | hit_i;
          sample_valid <= 1'b1;
          acc_v        <= '0;
          acc_i        <= '0;
          fcnt         <= '0;
          win_clip_v   <= 1'b0;
          win_clip_i   <= 1'b0;
        end else begin
          acc_v      <= sum_v;
          acc_i      <= sum_i;
          fcnt       <= fcnt + FW'(1);
          win_clip_v <= win_clip_v | hit_v;
          win_clip_i <= win_clip_i | hit_i;
        end
      end
    end
  end

endmodule

// File: tb/tb_vi_adc_capture.sv
// Bench for vi_adc_capture: three instances (plain, averaged, fast ticks)
// with serial ADC models and an expected-sample scoreboard.
module tb_vi_adc_capture;

  typedef struct packed {
    logic [15:0] v;
    logic [15:0] i;
    logic        cv;
    logic        ci;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a;
  logic        rst_bc;
  logic [2:0]  en;
  logic [15:0] vo [3];
  logic [15:0] io [3];
  logic [2:0]  sv;
  logic [2:0]  clv;
  logic [2:0]  cli;
  logic [2:0]  ov;
  logic [2:0]  cnv;
  logic [2:0]  sclk;
  logic [11:0] cv [3];
  logic [11:0] ci [3];

  vi_adc_capture_if ifa ();
  vi_adc_capture_if ifb ();
  vi_adc_capture_if ifc ();

  assign cnv  = {ifc.adc_cnv, ifb.adc_cnv, ifa.adc_cnv};
  assign sclk = {ifc.adc_sclk, ifb.adc_sclk, ifa.adc_sclk};

  vi_adc_capture dut_a (
    .clk(clk), .rst_n(rst_a), .enable(en[0]), .adc(ifa),
    .v_out(vo[0]), .i_out(io[0]), .sample_valid(sv[0]),
    .clip_v(clv[0]), .clip_i(cli[0]), .overrun(ov[0])
  );

  vi_adc_capture #(.SAMPLE_PERIOD(200), .AVG_LOG2(2)) dut_b (
    .clk(clk), .rst_n(rst_bc), .enable(en[1]), .adc(ifb),
    .v_out(vo[1]), .i_out(io[1]), .sample_valid(sv[1]),
    .clip_v(clv[1]), .clip_i(cli[1]), .overrun(ov[1])
  );

  vi_adc_capture #(.SAMPLE_PERIOD(100)) dut_c (
    .clk(clk), .rst_n(rst_bc), .enable(en[2]), .adc(ifc),
    .v_out(vo[2]), .i_out(io[2]), .sample_valid(sv[2]),
    .clip_v(clv[2]), .clip_i(cli[2]), .overrun(ov[2])
  );

  // ADC models: code latched at end of conversion, MSB first, next bit on SCLK fall.
  logic [11:0] ma_v, ma_i, mb_v, mb_i, mc_v, mc_i;

  initial begin
    ifa.adc_sdo_v = 1'b0;
    ifa.adc_sdo_i = 1'b0;
    forever begin
      @(negedge ifa.adc_cnv);
      ma_v = cv[0];
      ma_i = ci[0];
      ifa.adc_sdo_v = ma_v[11];
      ifa.adc_sdo_i = ma_i[11];
      for (int k = 0; k < 12; k++) begin
        @(negedge ifa.adc_sclk or posedge ifa.adc_cnv);
        if (ifa.adc_cnv) break;
        ma_v = ma_v << 1;
        ma_i = ma_i << 1;
        ifa.adc_sdo_v = ma_v[11];
        ifa.adc_sdo_i = ma_i[11];
      end
    end
  end

  initial begin
    ifb.adc_sdo_v = 1'b0;
    ifb.adc_sdo_i = 1'b0;
    forever begin
      @(negedge ifb.adc_cnv);
      mb_v = cv[1];
      mb_i = ci[1];
      ifb.adc_sdo_v = mb_v[11];
      ifb.adc_sdo_i = mb_i[11];
      for (int k = 0; k < 12; k++) begin
        @(negedge ifb.adc_sclk or posedge ifb.adc_cnv);
        if (ifb.adc_cnv) break;
        mb_v = mb_v << 1;
        mb_i = mb_i << 1;
        ifb.adc_sdo_v = mb_v[11];
        ifb.adc_sdo_i = mb_i[11];
      end
    end
  end

  initial begin
    ifc.adc_sdo_v = 1'b0;
    ifc.adc_sdo_i = 1'b0;
    forever begin
      @(negedge ifc.adc_cnv);
      mc_v = cv[2];
      mc_i = ci[2];
      ifc.adc_sdo_v = mc_v[11];
      ifc.adc_sdo_i = mc_i[11];
      for (int k = 0; k < 12; k++) begin
        @(negedge ifc.adc_sclk or posedge ifc.adc_cnv);
        if (ifc.adc_cnv) break;
        mc_v = mc_v << 1;
        mc_i = mc_i << 1;
        ifc.adc_sdo_v = mc_v[11];
        ifc.adc_sdo_i = mc_i[11];
      end
    end
  end

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int nsv [3];
  int nov = 0;
  int novab = 0;
  int ov_first = -1;
  string nm [3] = '{"a", "b", "c"};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
  endtask

  function automatic logic [15:0] q12(input logic [11:0] c);
    int t;
    t = (int'(c) - 2048) * 16;
    return 16'(t);
  endfunction

  function automatic logic clip12(input logic [11:0] c);
    return (c == 12'h000) || (c == 12'hFFF);
  endfunction

  function automatic exp_t mk(input logic [15:0] v, input logic [15:0] i,
                              input logic a, input logic b);
    exp_t e;
    e.v = v;
    e.i = i;
    e.cv = a;
    e.ci = b;
    return e;
  endfunction

  task automatic cmp_out(input int u, input exp_t e);
    chk({nm[u], "_v_out"}, 32'(vo[u]), 32'(e.v));
    chk({nm[u], "_i_out"}, 32'(io[u]), 32'(e.i));
    chk({nm[u], "_clip_v"}, 32'(clv[u]), 32'(e.cv));
    chk({nm[u], "_clip_i"}, 32'(cli[u]), 32'(e.ci));
  endtask

  // One clock: sample after the falling edge, service every scoreboard.
  task automatic step();
    exp_t e;
    bit got;
    @(negedge clk);
    #1;
    cyc++;
    for (int u = 0; u < 3; u++) begin
      if (sv[u]) begin
        nsv[u]++;
        got = 1'b0;
        case (u)
          0: if (sb0.size() > 0) begin e = sb0.pop_front(); got = 1'b1; end
          1: if (sb1.size() > 0) begin e = sb1.pop_front(); got = 1'b1; end
          default: if (sb2.size() > 0) begin e = sb2.pop_front(); got = 1'b1; end
        endcase
        chk({nm[u], "_strobe_expected"}, 32'(got), 1);
        if (got) cmp_out(u, e);
      end
    end
    if (ov[2]) begin
      nov++;
      if (ov_first < 0) ov_first = cyc;
    end
    if (ov[0] || ov[1]) novab++;
  endtask

  task automatic wait_cnv(input int u, input int bound, input string tag);
    int k = 0;
    while (cnv[u] && k < bound) begin step(); k++; end
    while (!cnv[u] && k < bound) begin step(); k++; end
    chk(tag, 32'(cnv[u]), 1);
  endtask

  task automatic wait_sv(input int u, input int n, input int bound,
                         input string tag);
    int k = 0;
    while (nsv[u] < n && k < bound) begin step(); k++; end
    chk(tag, nsv[u], n);
  endtask

  initial begin
    int chi, shi, rises, r1, r2, tv, t1, c0, k;
    logic ps;
    rst_a = 1'b0;
    rst_bc = 1'b0;
    en = '0;
    for (int u = 0; u < 3; u++) begin
      cv[u] = 12'h800;
      ci[u] = 12'h800;
      nsv[u] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_v_out", 32'(vo[0]), 0);
    chk("rst_i_out", 32'(io[0]), 0);
    chk("rst_valid", 32'(sv), 0);
    chk("rst_clip", 32'({clv, cli}), 0);
    chk("rst_cnv", 32'(cnv), 0);
    chk("rst_sclk", 32'(sclk), 0);
    chk("rst_overrun", 32'(ov), 0);
    chk("rst_b_v_out", 32'(vo[1]), 0);
    rst_a = 1'b1;
    rst_bc = 1'b1;

    // Plain capture, frame timing, strobe period.
    cv[0] = 12'h800;
    ci[0] = 12'hFFF;
    sb0.push_back(mk(16'h0000, 16'h7FF0, 1'b0, 1'b1));
    sb0.push_back(mk(16'h0000, 16'h7FF0, 1'b0, 1'b1));
    en[0] = 1'b1;
    wait_cnv(0, 1100, "a_first_cnv");
    chi = 0; shi = 0; rises = 0; r1 = -1; r2 = -1; tv = -1; ps = 1'b0;
    for (int n = 0; n < 200 && tv < 0; n++) begin
      if (cnv[0]) chi++;
      if (sclk[0]) shi++;
      if (sclk[0] && !ps) begin
        rises++;
        if (r1 < 0) r1 = n;
        else if (r2 < 0) r2 = n;
      end
      ps = sclk[0];
      if (sv[0]) tv = n;
      if (tv < 0) step();
    end
    t1 = cyc;
    chk("a_cnv_high", chi, 40);
    chk("a_sclk_pulses", rises, 12);
    chk("a_sclk_period", r2 - r1, 8);
    chk("a_sclk_high", shi, 48);
    chk("a_valid_latency", tv, 137);
    wait_sv(0, 2, 1100, "a_second_strobe");
    chk("a_strobe_period", cyc - t1, 1000);
    en[0] = 1'b0;
    chk("a_sb_empty", sb0.size(), 0);

    // Averaging over 4 frames.
    en[1] = 1'b1;
    sb1.push_back(mk(16'h0028, 16'hFFF4, 1'b0, 1'b0));
    for (int f = 0; f < 4; f++) begin
      wait_cnv(1, 300, "b_cnv_w1");
      cv[1] = 12'(12'h801 + f);
      ci[1] = (f < 3) ? 12'h7FF : 12'h800;
    end
    wait_sv(1, 1, 300, "b_win1");
    sb1.push_back(mk(16'h8000, 16'h1000, 1'b1, 1'b0));
    for (int f = 0; f < 4; f++) begin
      wait_cnv(1, 300, "b_cnv_w2");
      cv[1] = 12'h000;
      ci[1] = 12'h900;
    end
    wait_sv(1, 2, 300, "b_win2");

    // Abort mid-shift, then a fresh window.
    wait_cnv(1, 300, "b_cnv_w3");
    cv[1] = 12'h810;
    ci[1] = 12'h810;
    wait_cnv(1, 300, "b_cnv_abort");
    k = 0;
    while (!sclk[1] && k < 100) begin step(); k++; end
    chk("b_in_shift", 32'(sclk[1]), 1);
    en[1] = 1'b0;
    step();
    chk("b_abort_cnv", 32'(cnv[1]), 0);
    chk("b_abort_sclk", 32'(sclk[1]), 0);
    chk("b_hold_v", 32'(vo[1]), 'h8000);
    chk("b_hold_i", 32'(io[1]), 'h1000);
    chk("b_hold_clip_v", 32'(clv[1]), 1);
    repeat (300) step();
    chk("b_no_strobe", nsv[1], 2);
    cv[1] = 12'h802;
    ci[1] = 12'h7F0;
    sb1.push_back(mk(16'h0020, 16'hFF00, 1'b0, 1'b0));
    en[1] = 1'b1;
    for (int f = 0; f < 4; f++) wait_cnv(1, 300, "b_cnv_w4");
    wait_sv(1, 3, 300, "b_win_fresh");
    en[1] = 1'b0;
    chk("b_sb_empty", sb1.size(), 0);

    // Ticks faster than a frame: every other one is dropped.
    c0 = 0;
    en[2] = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_cnv(2, 300, "c_cnv");
      if (f == 0) c0 = cyc;
      if (f == 1) chk("c_frame_gap", cyc - c0, 200);
      cv[2] = 12'(12'h400 + 12'h155 * f);
      ci[2] = 12'(12'hFFF - 12'h3FF * f);
      sb2.push_back(mk(q12(cv[2]), q12(ci[2]), clip12(cv[2]),
                       clip12(ci[2])));
    end
    wait_sv(2, 4, 400, "c_strobes");
    en[2] = 1'b0;
    chk("c_overrun_count", nov, 4);
    chk("c_overrun_first", ov_first - c0, 99);
    chk("c_sb_empty", sb2.size(), 0);

    // Asynchronous reset during conversion.
    cv[0] = 12'hFFF;
    ci[0] = 12'h000;
    en[0] = 1'b1;
    wait_cnv(0, 1100, "a_cnv_rst");
    repeat (5) step();
    chk("a_in_conv", 32'(cnv[0]), 1);
    #2;
    rst_a = 1'b0;
    #1;
    chk("a_rst_cnv", 32'(cnv[0]), 0);
    chk("a_rst_sclk", 32'(sclk[0]), 0);
    chk("a_rst_v", 32'(vo[0]), 0);
    chk("a_rst_i", 32'(io[0]), 0);
    chk("a_rst_clip_i", 32'(cli[0]), 0);
    step();
    rst_a = 1'b1;
    sb0.push_back(mk(16'h7FF0, 16'h8000, 1'b1, 1'b1));
    wait_sv(0, 3, 1200, "a_restart");
    en[0] = 1'b0;
    chk("a_sb_empty_end", sb0.size(), 0);
    chk("ab_no_overrun", novab, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
